fifo_read_packer: RTL

//   Downstream consumer of the single-clock byte FIFO. Issues FIFO read requests, captures each

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_read_packer_if.sv | 18 +
 rtl/fifo_read_packer.sv | 65 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and helpers for the byte FIFO and its read packer
package fifo_pkg;
  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_PACK = 2;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // low n bits set; sized for the largest supported PACK of 8
  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    return 8'((9'd1 << n) - 9'd1);
  endfunction
endpackage

// File: rtl/fifo_read_packer_if.sv
// fifo_read_packer_if: FIFO read port, flush pulse and packed output stream
interface fifo_read_packer_if import fifo_pkg::*; #(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int PACK = FIFO_PACK,
  parameter int CNT_W = 16
);
  logic fifo_empty;
  logic [DATA_W-1:0] fifo_dataout;
  logic fifo_rden;
  logic flush;
  logic out_ready;
  logic out_valid;
  logic [DATA_W*PACK-1:0] out_data;
  logic [PACK-1:0] out_keep;
  logic [CNT_W-1:0] words_out;
  modport master (input fifo_empty, fifo_dataout, flush, out_ready, output fifo_rden, out_valid, out_data, out_keep, words_out);
  modport slave (output fifo_empty, fifo_dataout, flush, out_ready, input fifo_rden, out_valid, out_data, out_keep, words_out);
endinterface

// File: rtl/fifo_read_packer.sv
// fifo_read_packer: reads the byte FIFO and packs PACK lanes per output word, with partial flush
module fifo_read_packer import fifo_pkg::*; #(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int PACK = FIFO_PACK,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  fifo_read_packer_if.master bus
);
  localparam int LW = clog2(PACK + 1);
  localparam logic [LW:0] PK = PACK[LW:0];
  logic [LW-1:0] r_lanes;
  logic r_inflight, r_flush_pend, r_out_valid;
  logic [DATA_W*PACK-1:0] r_asm, r_out_data;
  logic [PACK-1:0] r_out_keep;
  logic [CNT_W-1:0] r_words;
  logic w_free, w_xfer, w_fl, w_load, w_accept;
  logic [LW:0] w_sum;
  assign w_free = !r_out_valid || bus.out_ready;
  assign w_xfer = ({1'b0, r_lanes} == PK) && w_free;
  assign w_fl = r_flush_pend && !r_inflight && w_free;
  assign w_load = w_xfer || (w_fl && r_lanes != '0);
  assign w_accept = r_out_valid && bus.out_ready;
  assign w_sum = {1'b0, r_lanes} + {{LW{1'b0}}, r_inflight} - (w_xfer ? PK : '0);
  // gated by reset so the request is low the moment reset asserts
  assign bus.fifo_rden = !reset && !bus.fifo_empty && !r_flush_pend && (w_sum < PK);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data = r_out_data;
  assign bus.out_keep = r_out_keep;
  assign bus.words_out = r_words;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_lanes <= '0;
      r_asm <= '0;
    end else if (w_load) begin
      r_lanes <= '0;
      r_asm <= '0;
    end else if (r_inflight) begin
      r_asm[r_lanes*DATA_W +: DATA_W] <= bus.fifo_dataout;
      r_lanes <= r_lanes + 1'b1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_out_keep <= '0;
      r_words <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data <= r_asm;
        r_out_keep <= PACK'(keep_mask(4'(r_lanes)));
      end else if (w_accept) r_out_valid <= 1'b0;
      if (w_accept) r_words <= r_words + 1'b1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_inflight <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_inflight <= bus.fifo_rden;
      r_flush_pend <= (bus.flush && (r_lanes != '0 || r_inflight)) || (r_flush_pend && !w_fl);
    end
endmodule
